// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 device-side responder.
// Holds the {RAS,CAS,WE} command encodings, the protocol-violation codes
// reported on err_code, and the per-bank open/closed state type.
package ddr3_pkg;

  localparam int NUM_BANKS = 8;

  // Command encodings as seen on {RAS,CAS,WE} while CS is low
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  // Protocol violation codes, numbered by reporting priority (lowest wins)
  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN  = 3'd1;
  localparam logic [2:0] ERR_RW_CLOSED = 3'd2;
  localparam logic [2:0] ERR_RW_TRCD   = 3'd3;
  localparam logic [2:0] ERR_ACT_TRP   = 3'd4;
  localparam logic [2:0] ERR_REF_BUSY  = 3'd5;
  localparam logic [2:0] ERR_IN_TRFC   = 3'd6;

  typedef enum logic {
    BANK_CLOSED = 1'b0,
    BANK_OPEN   = 1'b1
  } bank_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_bank_tracker.sv
// Per-bank state for the DDR3 responder: open/closed, latched row and a
// single countdown timer shared by tRCD (after ACT) and tRP (after PRE).
// The two never overlap because tRCD only matters while the bank is open
// and tRP only while it is closed.
//
// Ports:
//   CLK, RESET_n - clock, asynchronous active-low reset
//   act_en       - accepted ACT to this bank (opens it, latches act_row)
//   close_en     - accepted PRE / auto-precharge covering this bank
//   act_row      - row address presented with ACT
//   is_open      - bank currently open
//   open_row     - row latched by the last ACT
//   timer_done   - no tRCD/tRP wait pending
//   act_legal    - ACT would be accepted (closed and tRP satisfied)
//   rw_legal     - RD/WR would be accepted (open and tRCD satisfied)
module ddr3_bank_tracker
  import ddr3_pkg::*;
#(
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int ROW_W = 2,
  parameter int TMR_W = 2
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             act_en,
  input  logic             close_en,
  input  logic [ROW_W-1:0] act_row,
  output logic             is_open,
  output logic [ROW_W-1:0] open_row,
  output logic             timer_done,
  output logic             act_legal,
  output logic             rw_legal
);

  // The timer is loaded with (T-1) at the command edge so that it reads
  // zero exactly T edges later, which is when the follow-up becomes legal.
  localparam logic [TMR_W-1:0] LOAD_RCD = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] LOAD_RP  = TMR_W'(T_RP - 1);

  bank_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= BANK_CLOSED;
      row_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      timer_q <= timer_d;
    end
  end

  // Closing an already-closed bank leaves its timer untouched.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    timer_d = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    if (act_en) begin
      state_d = BANK_OPEN;
      row_d   = act_row;
      timer_d = LOAD_RCD;
    end else if (close_en && (state_q == BANK_OPEN)) begin
      state_d = BANK_CLOSED;
      timer_d = LOAD_RP;
    end
  end

  assign is_open    = (state_q == BANK_OPEN);
  assign open_row   = row_q;
  assign timer_done = (timer_q == '0);
  assign act_legal  = !is_open && timer_done;
  assign rw_legal   = is_open && timer_done;

endmodule

// File: rtl/ddr3_cmd_responder.sv
// Cycle-based DDR3 device-side responder. Decodes the command bus every
// clock, tracks 8 banks, enforces tRCD/tRP/tRFC, stores single-beat write
// data and returns read data CL cycles after RD. Violations pulse err and
// latch err_code; an erroring command changes no state.
//
// Ports:
//   CLK, RESET_n      - clock, asynchronous active-low reset
//   CS,RAS,CAS,WE     - active-low command pins
//   Addr_in, BA_in    - row/column address (A10 = auto-pre / all banks), bank
//   LDM, UDM, DQ_in   - write byte masks (1 = masked) and write data
//   DQ_out, DQ_valid  - read data and its valid flag
//   LDQS, UDQS        - strobes, high exactly when DQ_valid
//   bank_open         - per-bank open flags
//   err, err_code     - violation pulse and last violation code
module ddr3_cmd_responder
  import ddr3_pkg::*;
#(
  parameter int CL    = 5,
  parameter int WL    = 4,
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_RFC = 10,
  parameter int ROW_W = 2,
  parameter int COL_W = 3
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr_in,
  input  logic [2:0]  BA_in,
  input  logic        LDM,
  input  logic        UDM,
  input  logic [15:0] DQ_in,
  output logic [15:0] DQ_out,
  output logic        DQ_valid,
  output logic        LDQS,
  output logic        UDQS,
  output logic [7:0]  bank_open,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int IDX_W = 3 + ROW_W + COL_W;
  localparam int TMR_W = $clog2(max_int(T_RCD, T_RP) + 1);
  localparam int RFC_W = $clog2(T_RFC + 1);
  localparam logic [RFC_W-1:0] LOAD_RFC = RFC_W'(T_RFC - 1);

  cmd_e                 cmd;
  logic                 a10;
  logic [IDX_W-1:0]     cmd_idx;
  logic [ROW_W-1:0]     bank_row [NUM_BANKS];
  logic [NUM_BANKS-1:0] timer_done;
  logic [NUM_BANKS-1:0] act_legal;
  logic [NUM_BANKS-1:0] rw_legal;
  logic [NUM_BANKS-1:0] act_en;
  logic [NUM_BANKS-1:0] close_en;
  logic                 err_hit;
  logic [2:0]           err_val;
  logic                 rd_push;
  logic                 wr_push;
  logic                 ref_go;
  logic [RFC_W-1:0]     rfc_timer;
  logic                 rfc_busy;
  logic                 rd_vld [CL];
  logic [IDX_W-1:0]     rd_idx [CL];
  logic                 wr_vld [WL];
  logic [IDX_W-1:0]     wr_idx [WL];
  logic [15:0]          mem [2**IDX_W];
  logic                 unused_addr_bits;

  assign cmd     = CS ? CMD_NOP : cmd_e'({RAS, CAS, WE});
  assign a10     = Addr_in[10];
  assign cmd_idx = {BA_in, bank_row[BA_in], Addr_in[COL_W-1:0]};
  assign rfc_busy = (rfc_timer != '0);
  assign unused_addr_bits = ^{Addr_in[14:11], Addr_in[9:COL_W]};

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      ddr3_bank_tracker #(
        .T_RCD (T_RCD),
        .T_RP  (T_RP),
        .ROW_W (ROW_W),
        .TMR_W (TMR_W)
      ) u_tracker (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .act_en     (act_en[b]),
        .close_en   (close_en[b]),
        .act_row    (Addr_in[ROW_W-1:0]),
        .is_open    (bank_open[b]),
        .open_row   (bank_row[b]),
        .timer_done (timer_done[b]),
        .act_legal  (act_legal[b]),
        .rw_legal   (rw_legal[b])
      );
    end
  endgenerate

  // Legality check. Within each command the checks run in ascending code
  // order, so the first hit is the lowest-numbered applicable violation.
  always_comb begin
    err_hit = 1'b0;
    err_val = ERR_NONE;
    case (cmd)
      CMD_ACT: begin
        if (!act_legal[BA_in]) begin
          err_hit = 1'b1;
          err_val = bank_open[BA_in] ? ERR_ACT_OPEN : ERR_ACT_TRP;
        end else if (rfc_busy) begin
          err_hit = 1'b1;
          err_val = ERR_IN_TRFC;
        end
      end
      CMD_RD, CMD_WR: begin
        if (!rw_legal[BA_in]) begin
          err_hit = 1'b1;
          err_val = bank_open[BA_in] ? ERR_RW_TRCD : ERR_RW_CLOSED;
        end else if (rfc_busy) begin
          err_hit = 1'b1;
          err_val = ERR_IN_TRFC;
        end
      end
      CMD_REF: begin
        if ((|bank_open) || !(&timer_done)) begin
          err_hit = 1'b1;
          err_val = ERR_REF_BUSY;
        end else if (rfc_busy) begin
          err_hit = 1'b1;
          err_val = ERR_IN_TRFC;
        end
      end
      CMD_PRE, CMD_MRS, CMD_ZQ: begin
        if (rfc_busy) begin
          err_hit = 1'b1;
          err_val = ERR_IN_TRFC;
        end
      end
      default: ;
    endcase
  end

  // Effects of an accepted command; a rejected one produces none.
  always_comb begin
    act_en   = '0;
    close_en = '0;
    rd_push  = 1'b0;
    wr_push  = 1'b0;
    ref_go   = 1'b0;
    if (!err_hit) begin
      case (cmd)
        CMD_ACT: act_en[BA_in] = 1'b1;
        CMD_RD: begin
          rd_push = 1'b1;
          if (a10) close_en[BA_in] = 1'b1;
        end
        CMD_WR: begin
          wr_push = 1'b1;
          if (a10) close_en[BA_in] = 1'b1;
        end
        CMD_PRE: begin
          if (a10) close_en = '1;
          else     close_en[BA_in] = 1'b1;
        end
        CMD_REF: ref_go = 1'b1;
        default: ;
      endcase
    end
  end

  // Global refresh timer: zero means tRFC has elapsed.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      rfc_timer <= '0;
    end else if (ref_go) begin
      rfc_timer <= LOAD_RFC;
    end else if (rfc_busy) begin
      rfc_timer <= rfc_timer - 1'b1;
    end
  end

  // Read and write index pipelines. An entry pushed at edge t sits in
  // stage N-1 after edge t+N-1 and completes at edge t+N.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < CL; i++) begin
        rd_vld[i] <= 1'b0;
        rd_idx[i] <= '0;
      end
      for (int i = 0; i < WL; i++) begin
        wr_vld[i] <= 1'b0;
        wr_idx[i] <= '0;
      end
    end else begin
      rd_vld[0] <= rd_push;
      rd_idx[0] <= cmd_idx;
      for (int i = 1; i < CL; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_idx[i] <= rd_idx[i-1];
      end
      wr_vld[0] <= wr_push;
      wr_idx[0] <= cmd_idx;
      for (int i = 1; i < WL; i++) begin
        wr_vld[i] <= wr_vld[i-1];
        wr_idx[i] <= wr_idx[i-1];
      end
    end
  end

  // Storage array, deliberately not reset. Byte lanes with their mask set
  // keep their old contents.
  always_ff @(posedge CLK) begin
    if (wr_vld[WL-1]) begin
      if (!LDM) mem[wr_idx[WL-1]][7:0]  <= DQ_in[7:0];
      if (!UDM) mem[wr_idx[WL-1]][15:8] <= DQ_in[15:8];
    end
  end

  // Read return. Reading mem with the same edge as a completing write
  // yields the pre-write value, which is the intended collision rule.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      DQ_out   <= '0;
      DQ_valid <= 1'b0;
    end else begin
      DQ_valid <= rd_vld[CL-1];
      DQ_out   <= rd_vld[CL-1] ? mem[rd_idx[CL-1]] : 16'h0000;
    end
  end

  assign LDQS = DQ_valid;
  assign UDQS = DQ_valid;

  // Error pulse for one cycle; the code is held until the next violation.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      err <= err_hit;
      if (err_hit) err_code <= err_val;
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed self-checking bench for ddr3_cmd_responder with default
// parameters (CL=5, WL=4, T_RCD=3, T_RP=3, T_RFC=10).
module tb_ddr3_cmd_responder;

  localparam int CL = 5;
  localparam int WL = 4;

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;

  logic        CLK;
  logic        RESET_n;
  logic        CS, RAS, CAS, WE;
  logic [14:0] Addr_in;
  logic [2:0]  BA_in;
  logic        LDM, UDM;
  logic [15:0] DQ_in;
  logic [15:0] DQ_out;
  logic        DQ_valid, LDQS, UDQS;
  logic [7:0]  bank_open;
  logic        err;
  logic [2:0]  err_code;

  int checkCount = 0;
  int passCount  = 0;
  logic sawValid;

  ddr3_cmd_responder dut (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .CS       (CS),
    .RAS      (RAS),
    .CAS      (CAS),
    .WE       (WE),
    .Addr_in  (Addr_in),
    .BA_in    (BA_in),
    .LDM      (LDM),
    .UDM      (UDM),
    .DQ_in    (DQ_in),
    .DQ_out   (DQ_out),
    .DQ_valid (DQ_valid),
    .LDQS     (LDQS),
    .UDQS     (UDQS),
    .bank_open(bank_open),
    .err      (err),
    .err_code (err_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    else
      passCount++;
  endtask

  // Drive one command so it is sampled at the next rising edge, then
  // return 1ns after that edge with the bus back at deselect.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [2:0] ba,
                               input logic [14:0] addr);
    @(negedge CLK);
    CS = 1'b0;
    {RAS, CAS, WE} = cmd;
    BA_in = ba;
    Addr_in = addr;
    @(posedge CLK);
    #1;
    CS = 1'b1;
    {RAS, CAS, WE} = 3'b111;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Called 1ns after a RD edge: data must appear exactly CL edges later.
  task automatic readCheck(input string tag, input logic [15:0] expected);
    idleCycles(CL - 1);
    checkOutput({tag, "_early"}, DQ_valid, 1'b0);
    idleCycles(1);
    checkOutput({tag, "_valid"}, DQ_valid, 1'b1);
    checkOutput({tag, "_data"}, DQ_out, expected);
    checkOutput({tag, "_dqs"}, {LDQS, UDQS}, 2'b11);
    idleCycles(1);
    checkOutput({tag, "_drop"}, {DQ_valid, LDQS, UDQS}, 3'b000);
    checkOutput({tag, "_zero"}, DQ_out, 16'h0000);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_dq"}, DQ_out, 16'h0000);
    checkOutput({tag, "_valid"}, {DQ_valid, LDQS, UDQS}, 3'b000);
    checkOutput({tag, "_banks"}, bank_open, 8'h00);
    checkOutput({tag, "_err"}, err, 1'b0);
    checkOutput({tag, "_code"}, err_code, 3'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET_n = 1'b0;
    CS = 1'b1; {RAS, CAS, WE} = 3'b111;
    Addr_in = '0; BA_in = '0;
    LDM = 1'b0; UDM = 1'b0; DQ_in = '0;
    idleCycles(3);
    checkResetState("reset");
    @(negedge CLK);
    RESET_n = 1'b1;

    // Basic write then read on bank 2, row 1, column 3
    $display("[TB] write/read round trip");
    applyStimulus(C_ACT, 3'd2, 15'd1);
    checkOutput("act_b2_err", err, 1'b0);
    checkOutput("act_b2_open", bank_open, 8'h04);
    DQ_in = 16'hA5C3;
    idleCycles(2);
    applyStimulus(C_WR, 3'd2, 15'd3);
    checkOutput("wr_trcd_err", err, 1'b0);
    idleCycles(WL);
    applyStimulus(C_RD, 3'd2, 15'd3);
    checkOutput("rd_err", err, 1'b0);
    readCheck("rd_a5c3", 16'hA5C3);

    // Low byte masked write over 16'hFFFF
    $display("[TB] byte mask");
    DQ_in = 16'hFFFF;
    applyStimulus(C_WR, 3'd2, 15'd4);
    idleCycles(WL);
    DQ_in = 16'h1234;
    LDM = 1'b1;
    applyStimulus(C_WR, 3'd2, 15'd4);
    checkOutput("wr_mask_err", err, 1'b0);
    idleCycles(WL);
    LDM = 1'b0;
    applyStimulus(C_RD, 3'd2, 15'd4);
    readCheck("rd_mask", 16'h12FF);

    // RD two cycles after ACT violates tRCD
    $display("[TB] tRCD violation");
    applyStimulus(C_ACT, 3'd5, 15'd2);
    idleCycles(1);
    applyStimulus(C_RD, 3'd5, 15'd0);
    checkOutput("trcd_err", err, 1'b1);
    checkOutput("trcd_code", err_code, 3'd3);
    idleCycles(1);
    checkOutput("trcd_err_pulse", err, 1'b0);
    checkOutput("trcd_code_held", err_code, 3'd3);
    idleCycles(CL - 1);
    checkOutput("trcd_no_data", DQ_valid, 1'b0);

    // Refresh rules
    $display("[TB] refresh");
    applyStimulus(C_ACT, 3'd0, 15'd0);
    applyStimulus(C_REF, 3'd0, 15'd0);
    checkOutput("ref_open_err", err, 1'b1);
    checkOutput("ref_open_code", err_code, 3'd5);
    applyStimulus(C_PRE, 3'd0, 15'h0400);
    checkOutput("pre_all_err", err, 1'b0);
    checkOutput("pre_all_banks", bank_open, 8'h00);
    idleCycles(2);
    applyStimulus(C_REF, 3'd0, 15'd0);
    checkOutput("ref_ok_err", err, 1'b0);
    idleCycles(4);
    applyStimulus(C_ACT, 3'd0, 15'd0);
    checkOutput("trfc_err", err, 1'b1);
    checkOutput("trfc_code", err_code, 3'd6);
    checkOutput("trfc_no_open", bank_open, 8'h00);
    idleCycles(4);
    applyStimulus(C_ACT, 3'd0, 15'd0);
    checkOutput("after_trfc_err", err, 1'b0);
    checkOutput("after_trfc_open", bank_open, 8'h01);
    checkOutput("after_trfc_code", err_code, 3'd6);

    // Auto-precharge and tRP
    $display("[TB] auto-precharge");
    DQ_in = 16'hBEEF;
    idleCycles(2);
    applyStimulus(C_WR, 3'd0, 15'h0407);
    checkOutput("wr_ap_err", err, 1'b0);
    checkOutput("wr_ap_closed", bank_open, 8'h00);
    idleCycles(1);
    applyStimulus(C_ACT, 3'd0, 15'd0);
    checkOutput("trp_err", err, 1'b1);
    checkOutput("trp_code", err_code, 3'd4);
    applyStimulus(C_ACT, 3'd0, 15'd0);
    checkOutput("trp_ok_err", err, 1'b0);
    checkOutput("trp_ok_open", bank_open, 8'h01);

    // MRS is accepted and has no effect
    applyStimulus(C_MRS, 3'd0, 15'd0);
    checkOutput("mrs_err", err, 1'b0);
    checkOutput("mrs_banks", bank_open, 8'h01);

    // Reset while a read is in flight
    $display("[TB] reset during read");
    idleCycles(1);
    applyStimulus(C_RD, 3'd0, 15'd0);
    checkOutput("rd_pre_reset_err", err, 1'b0);
    idleCycles(2);
    RESET_n = 1'b0;
    #1;
    checkResetState("mid_reset");
    sawValid = 1'b0;
    for (int i = 0; i < CL + 2; i++) begin
      @(posedge CLK);
      #1;
      sawValid = sawValid | DQ_valid;
    end
    @(negedge CLK);
    RESET_n = 1'b1;
    for (int i = 0; i < CL + 2; i++) begin
      @(posedge CLK);
      #1;
      sawValid = sawValid | DQ_valid;
    end
    checkOutput("dropped_read", sawValid, 1'b0);

    // Storage survives reset; async reset removes DQ_valid mid-beat
    $display("[TB] async drop of valid");
    applyStimulus(C_ACT, 3'd2, 15'd1);
    idleCycles(2);
    applyStimulus(C_RD, 3'd2, 15'd3);
    idleCycles(CL);
    checkOutput("persist_valid", DQ_valid, 1'b1);
    checkOutput("persist_data", DQ_out, 16'hA5C3);
    @(negedge CLK);
    RESET_n = 1'b0;
    #1;
    checkOutput("async_valid", {DQ_valid, LDQS, UDQS}, 3'b000);
    checkOutput("async_dq", DQ_out, 16'h0000);
    checkOutput("async_banks", bank_open, 8'h00);
    idleCycles(1);
    @(negedge CLK);
    RESET_n = 1'b1;
    idleCycles(1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
